// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, axis-length derivation and the lock/run FSM encoding.
// Default timing is 640x480 at a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_FP_DEF        = 16;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_BP_DEF        = 48;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_FP_DEF        = 10;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_BP_DEF        = 33;
    localparam int LOCK_SETTLE_DEF = 16;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int HT_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int VT_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// Wrapping 0..MODULUS-1 counter with synchronous clear (priority over enable)
// and a terminal-count flag that is high while the counter sits on its last value.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int WIDTH   = CNT_W,
    parameter int MODULUS = HT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: qualifies the DCM lock, then runs h/v counters and
// emits registered sync, data-enable, position and start-of-line/frame strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_SETTLE = LOCK_SETTLE_DEF
) (
    input  logic             CLK_IN,
    input  logic             RST_N_IN,
    input  logic             LOCKED_IN,
    output logic             HSYNC_OUT,
    output logic             VSYNC_OUT,
    output logic             DE_OUT,
    output logic [CNT_W-1:0] X_OUT,
    output logic [CNT_W-1:0] Y_OUT,
    output logic             LINE_START_OUT,
    output logic             FRAME_START_OUT,
    output logic             READY_OUT
);

    localparam int HT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int SW = $clog2(LOCK_SETTLE) + 1;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic [1:0]       sync_reg;
    logic             lock_s;
    state_t           state_reg;
    logic [SW-1:0]    settle_reg;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_tc;
    logic             v_tc_unused;
    logic             run;
    logic             cnt_clr;
    logic             in_active;
    logic             in_hsync;
    logic             in_vsync;

    logic             hsync_reg;
    logic             vsync_reg;
    logic             de_reg;
    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] y_reg;
    logic             line_start_reg;
    logic             frame_start_reg;
    logic             ready_reg;

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], LOCKED_IN};
        end
    end

    assign lock_s = sync_reg[1];
    assign run    = (state_reg == ST_RUN);
    // Counters sit at zero outside RUN and are zeroed on the RUN->WAIT_LOCK edge,
    // so the first RUN cycle always decodes position (0,0).
    assign cnt_clr = !run || !lock_s;

    vga_axis_cnt #(.WIDTH(CNT_W), .MODULUS(HT)) u_h_cnt (
        .clk   (CLK_IN),
        .rst_n (RST_N_IN),
        .en    (run),
        .clr   (cnt_clr),
        .cnt   (h_cnt),
        .tc    (h_tc)
    );

    vga_axis_cnt #(.WIDTH(CNT_W), .MODULUS(VT)) u_v_cnt (
        .clk   (CLK_IN),
        .rst_n (RST_N_IN),
        .en    (run && h_tc),
        .clr   (cnt_clr),
        .cnt   (v_cnt),
        .tc    (v_tc_unused)
    );

    assign in_active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign in_hsync  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign in_vsync  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_reg       <= ST_WAIT_LOCK;
            settle_reg      <= '0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            ready_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_WAIT_LOCK: begin
                    settle_reg <= '0;
                    if (lock_s) begin
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_reg <= ST_WAIT_LOCK;
                    end else if (settle_reg == SETTLE_LAST) begin
                        state_reg <= ST_RUN;
                    end else begin
                        settle_reg <= settle_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_reg <= ST_WAIT_LOCK;
                    end
                end
                default: begin
                    state_reg <= ST_WAIT_LOCK;
                end
            endcase

            // Output decode uses the pre-edge state and counters: one cycle of latency.
            hsync_reg       <= (run && in_hsync) ? SYNC_POL : ~SYNC_POL;
            vsync_reg       <= (run && in_vsync) ? SYNC_POL : ~SYNC_POL;
            de_reg          <= run && in_active;
            x_reg           <= (run && in_active) ? h_cnt : '0;
            y_reg           <= (run && in_active) ? v_cnt : '0;
            line_start_reg  <= run && (h_cnt == '0);
            frame_start_reg <= run && (h_cnt == '0) && (v_cnt == '0);
            ready_reg       <= run;
        end
    end

    assign HSYNC_OUT       = hsync_reg;
    assign VSYNC_OUT       = vsync_reg;
    assign DE_OUT          = de_reg;
    assign X_OUT           = x_reg;
    assign Y_OUT           = y_reg;
    assign LINE_START_OUT  = line_start_reg;
    assign FRAME_START_OUT = frame_start_reg;
    assign READY_OUT       = ready_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a shrunken raster (32x20 totals) so whole frames fit in a short run;
// a streak-based timing model checks every cycle, directed sequences cover lock and reset corners.
module tb_vga_sync_gen;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 4;
    localparam int LS = 16;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [25:0] IDLE_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       locked = 1'b0;
    logic       hsync, vsync, de, line_start, frame_start, ready;
    logic [9:0] x_pos, y_pos;
    logic [25:0] dut_vec;

    always #20 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .LOCK_SETTLE(LS)
    ) dut (
        .CLK_IN          (clk),
        .RST_N_IN        (rst_n),
        .LOCKED_IN       (locked),
        .HSYNC_OUT       (hsync),
        .VSYNC_OUT       (vsync),
        .DE_OUT          (de),
        .X_OUT           (x_pos),
        .Y_OUT           (y_pos),
        .LINE_START_OUT  (line_start),
        .FRAME_START_OUT (frame_start),
        .READY_OUT       (ready)
    );

    assign dut_vec = {hsync, vsync, de, x_pos, y_pos, line_start, frame_start, ready};

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // s = number of consecutive clock edges whose synchronized lock was 1.
    // RUN begins once s reaches LS+1 (one WAIT_LOCK edge plus LS settle edges);
    // the raster position is then just the elapsed cycles in RUN.
    function automatic logic [25:0] model_out(input int s);
        int t, h, v;
        logic run_m, hs_m, vs_m, de_m;
        logic [9:0] x_m, y_m;
        run_m = (s >= LS + 1);
        t = run_m ? s - (LS + 1) : 0;
        h = t % HT;
        v = (t / HT) % VT;
        de_m = run_m && (h < HA) && (v < VA);
        hs_m = !(run_m && (h >= HA + HFP) && (h < HA + HFP + HS));
        vs_m = !(run_m && (v >= VA + VFP) && (v < VA + VFP + VS));
        x_m = de_m ? 10'(h) : 10'd0;
        y_m = de_m ? 10'(v) : 10'd0;
        return {hs_m, vs_m, de_m, x_m, y_m, run_m && (h == 0), run_m && (h == 0) && (v == 0), run_m};
    endfunction

    int          m_streak = 0;
    logic        m_d1 = 1'b0, m_d2 = 1'b0;
    logic [25:0] m_exp;

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_d1 = 1'b0;
            m_d2 = 1'b0;
            m_streak = 0;
            m_exp = IDLE_VEC;
        end else begin
            m_exp = model_out(m_streak);
            m_streak = m_d2 ? m_streak + 1 : 0;
            m_d2 = m_d1;
            m_d1 = locked;
        end
        #1;
        if (chk_en) check("cycle", 32'(dut_vec), 32'(m_exp));
    end

    typedef struct {
        int glitch_at;
        int exp_edge;
    } vec_t;

    vec_t tbl[4];

    task automatic do_reset();
        @(negedge clk);
        locked = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Called just after driving at a negedge; returns the posedge index at which READY rose.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int rise, found, n;
        logic fs_at;
        int de_cnt, first_ls, next_fs, hs_fall, hs_low, vs_fall, vs_low;
        logic prev_hs, prev_vs;

        // glitch_at: sample index (1 = first edge after LOCKED_IN rises) held low; 0 = clean lock
        tbl[0] = '{glitch_at: 0,  exp_edge: 20};
        tbl[1] = '{glitch_at: 2,  exp_edge: 22};
        tbl[2] = '{glitch_at: 9,  exp_edge: 29};
        tbl[3] = '{glitch_at: 17, exp_edge: 37};

        #5 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_idle", 32'(dut_vec), 32'(IDLE_VEC));
        chk_en = 1'b1;

        for (int k = 0; k < 4; k++) begin
            do_reset();
            rise = -1;
            fs_at = 1'b0;
            for (int e = 1; e <= 60; e++) begin
                locked = (e == tbl[k].glitch_at) ? 1'b0 : 1'b1;
                @(negedge clk);
                if (ready) begin
                    rise = e;
                    fs_at = frame_start;
                    break;
                end
            end
            $display("[TB] lock vector glitch_at=%0d ready_edge=%0d", tbl[k].glitch_at, rise);
            check($sformatf("ready_edge_g%0d", tbl[k].glitch_at), 32'(rise), 32'(tbl[k].exp_edge));
            check($sformatf("fs_with_ready_g%0d", tbl[k].glitch_at), 32'(fs_at), 32'd1);
        end

        // One full frame of measurements, starting from a FRAME_START strobe.
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1;
                break;
            end
        end
        check("frame_start_found", 32'(found), 32'd1);
        de_cnt = de ? 1 : 0;
        first_ls = -1; next_fs = -1; hs_fall = -1; hs_low = 0; vs_fall = -1; vs_low = 0;
        prev_hs = hsync;
        prev_vs = vsync;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            @(negedge clk);
            if (frame_start) begin
                next_fs = c;
                break;
            end
            if (line_start && first_ls < 0) first_ls = c;
            if (de) de_cnt++;
            if (prev_hs && !hsync && hs_fall < 0) hs_fall = c;
            if (c < HT && !hsync) hs_low++;
            if (prev_vs && !vsync && vs_fall < 0) vs_fall = c;
            if (!vsync) vs_low++;
            prev_hs = hsync;
            prev_vs = vsync;
        end
        $display("[TB] frame: period=%0d line=%0d de=%0d hs_at=%0d vs_at=%0d", next_fs, first_ls, de_cnt, hs_fall, vs_fall);
        check("line_period", 32'(first_ls), 32'(HT));
        check("frame_period", 32'(next_fs), 32'(FRAME));
        check("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        check("hsync_start", 32'(hs_fall), 32'(HA + HFP));
        check("hsync_width", 32'(hs_low), 32'(HS));
        check("vsync_start", 32'(vs_fall), 32'((VA + VFP) * HT));
        check("vsync_width", 32'(vs_low), 32'(VS * HT));

        // Lock loss in the middle of active video.
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (x_pos == 10'd10 && y_pos == 10'd5) begin
                found = 1;
                break;
            end
        end
        check("drop_pos_found", 32'(found), 32'd1);
        locked = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] lock drop: de=%0b hs=%0b vs=%0b ready=%0b", de, hsync, vsync, ready);
        check("drop_idle", 32'({de, hsync, vsync, ready}), 32'(4'b0110));
        locked = 1'b1;
        wait_ready(n);
        $display("[TB] relock: ready_edge=%0d x=%0d y=%0d", n, x_pos, y_pos);
        check("relock_edge", 32'(n), 32'd20);
        check("relock_origin", 32'({frame_start, de, x_pos, y_pos}), 32'({1'b1, 1'b1, 10'd0, 10'd0}));

        // Asynchronous reset in mid-line, checked before any further clock edge.
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (de && x_pos == 10'd5) begin
                found = 1;
                break;
            end
        end
        check("midline_found", 32'(found), 32'd1);
        #5 rst_n = 1'b0;
        #1;
        $display("[TB] async reset: outputs=%0h", dut_vec);
        check("async_reset", 32'(dut_vec), 32'(IDLE_VEC));
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        $display("[TB] post-reset: ready_edge=%0d", n);
        check("requalify_edge", 32'(n), 32'd20);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
